// File: rtl/stage_c_execute.sv
// Execute stage: INC/DEC/IN result computation and OUT/IN byte handshakes ahead of write-back.
// Optional macro EXECUTE_FORWARD_EN adds a one-entry result forward for back-to-back ops on one cell.
module stage_c_execute #(
    parameter int A_WIDTH    = 12,
    parameter int D_WIDTH    = 8,
    parameter int OPCODE_MSB = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [OPCODE_MSB:0]   operation_in,
    input  logic [A_WIDTH-1:0]    dp_in,
    input  logic [D_WIDTH-1:0]    d_in,
    input  logic                  drdy_in,
    output logic                  ack,
    output logic [OPCODE_MSB:0]   operation,
    output logic [D_WIDTH-1:0]    a,
    output logic                  drdy,
    input  logic                  ack_in,
    input  logic [D_WIDTH-1:0]    in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [D_WIDTH-1:0]    out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    // One-hot opcode bit positions shared with the read and write-back stages
    localparam int B_INC = 0;
    localparam int B_DEC = 1;
    localparam int B_OUT = 4;
    localparam int B_IN  = 5;

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] WAIT_IN  = 2'd1;
    localparam logic [1:0] WAIT_OUT = 2'd2;

    logic [1:0]          state;
    logic [OPCODE_MSB:0] op_lat;
    logic                hit;
    logic [D_WIDTH-1:0]  opnd;
    logic [D_WIDTH-1:0]  result;
    logic                is_inc, is_dec, is_in, is_out, need_d;
    logic                accept, run_complete;

    assign is_inc = operation_in[B_INC];
    assign is_dec = operation_in[B_DEC];
    assign is_in  = operation_in[B_IN];
    assign is_out = operation_in[B_OUT];
    assign need_d = is_inc | is_dec | is_out;

    assign ack          = (state == RUN) && ack_in && !(need_d && !drdy_in && !hit);
    assign accept       = ack && (|operation_in);
    assign run_complete = accept && !is_out && !(is_in && !in_valid);

    assign in_ready = ((state == RUN) && accept && !is_out && is_in && in_valid) ||
                      ((state == WAIT_IN) && in_valid);

    always_comb begin
        result = opnd;
        if (is_out)
            result = opnd;
        else if (is_in)
            result = in_data;
        else if (is_inc)
            result = opnd + D_WIDTH'(1);
        else if (is_dec)
            result = opnd - D_WIDTH'(1);
    end

`ifdef EXECUTE_FORWARD_EN
    logic               fwd_valid;
    logic [A_WIDTH-1:0] fwd_dp;
    logic [A_WIDTH-1:0] dp_lat;
    logic [D_WIDTH-1:0] fwd_data;

    assign hit  = fwd_valid && (fwd_dp == dp_in);
    assign opnd = hit ? fwd_data : d_in;

    // Track the most recent cell write so a dependent op need not wait for DRAM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwd_valid <= 1'b0;
            fwd_dp    <= '0;
            fwd_data  <= '0;
            dp_lat    <= '0;
        end else begin
            if ((state == RUN) && run_complete && (is_inc || is_dec || is_in)) begin
                fwd_valid <= 1'b1;
                fwd_dp    <= dp_in;
                fwd_data  <= result;
            end else if ((state == WAIT_IN) && in_valid) begin
                fwd_valid <= 1'b1;
                fwd_dp    <= dp_lat;
                fwd_data  <= in_data;
            end
            if ((state == RUN) && accept && !is_out && is_in && !in_valid)
                dp_lat <= dp_in;
        end
    end
`else
    logic unused_dp;

    assign unused_dp = ^dp_in;
    assign hit       = 1'b0;
    assign opnd      = d_in;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            op_lat    <= '0;
            operation <= '0;
            a         <= '0;
            drdy      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            operation <= '0;
            drdy      <= 1'b0;
            case (state)
                RUN: begin
                    if (accept) begin
                        if (is_out) begin
                            out_data  <= opnd;
                            out_valid <= 1'b1;
                            op_lat    <= operation_in;
                            state     <= WAIT_OUT;
                        end else if (is_in && !in_valid) begin
                            op_lat <= operation_in;
                            state  <= WAIT_IN;
                        end else begin
                            operation <= operation_in;
                            a         <= result;
                            drdy      <= drdy_in | hit;
                        end
                    end
                end
                WAIT_IN: begin
                    if (in_valid) begin
                        a         <= in_data;
                        operation <= op_lat;
                        drdy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                WAIT_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        operation <= op_lat;
                        a         <= out_data;
                        drdy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_c_execute.sv
// Scoreboard bench for stage_c_execute: directed stimulus pushes expected write-back ops, a monitor pops them.
module tb_stage_c_execute;

    localparam int A_WIDTH    = 12;
    localparam int D_WIDTH    = 8;
    localparam int OPCODE_MSB = 7;

    localparam logic [7:0] OP_INC   = 8'h01;
    localparam logic [7:0] OP_DEC   = 8'h02;
    localparam logic [7:0] OP_RIGHT = 8'h04;
    localparam logic [7:0] OP_OUT   = 8'h10;
    localparam logic [7:0] OP_IN    = 8'h20;

    logic                clk;
    logic                reset;
    logic [OPCODE_MSB:0] operation_in;
    logic [A_WIDTH-1:0]  dp_in;
    logic [D_WIDTH-1:0]  d_in;
    logic                drdy_in;
    logic                ack;
    logic [OPCODE_MSB:0] operation;
    logic [D_WIDTH-1:0]  a;
    logic                drdy;
    logic                ack_in;
    logic [D_WIDTH-1:0]  in_data;
    logic                in_valid;
    logic                in_ready;
    logic [D_WIDTH-1:0]  out_data;
    logic                out_valid;
    logic                out_ready;

    typedef struct {
        logic [7:0] op;
        logic [7:0] a;
        logic       drdy;
        bit         chk_drdy;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;

    stage_c_execute #(
        .A_WIDTH   (A_WIDTH),
        .D_WIDTH   (D_WIDTH),
        .OPCODE_MSB(OPCODE_MSB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .operation_in(operation_in),
        .dp_in       (dp_in),
        .d_in        (d_in),
        .drdy_in     (drdy_in),
        .ack         (ack),
        .operation   (operation),
        .a           (a),
        .drdy        (drdy),
        .ack_in      (ack_in),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic set_op(input logic [7:0] op, input logic [11:0] dp, input logic [7:0] d,
                          input logic rdy);
        operation_in = op;
        dp_in        = dp;
        d_in         = d;
        drdy_in      = rdy;
    endtask

    task automatic expect_wb(input logic [7:0] op, input logic [7:0] val, input bit chk_drdy);
        sb.push_back('{op, val, 1'b1, chk_drdy});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && operation !== 8'h00) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_op actual=0x%0h required=none", operation);
            end else begin
                e = sb.pop_front();
                check("wb_op", 32'(operation), 32'(e.op));
                check("wb_a", 32'(a), 32'(e.a));
                if (e.chk_drdy)
                    check("wb_drdy", 32'(drdy), 32'(e.drdy));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        ack_in    = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_op(8'h00, 12'd0, 8'h00, 1'b0);
        #2;
        check("rst_operation", 32'(operation), 32'h0);
        check("rst_a", 32'(a), 32'h0);
        check("rst_drdy", 32'(drdy), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        tick;
        tick;
        reset = 1'b1;

        // INC / DEC wrap and pass-through op
        set_op(OP_INC, 12'd1, 8'hFF, 1'b1);
        #2 check("ack_inc_wrap", 32'(ack), 32'h1);
        expect_wb(OP_INC, 8'h00, 1'b1);
        tick;
        set_op(OP_DEC, 12'd2, 8'h00, 1'b1);
        #2 check("ack_dec_wrap", 32'(ack), 32'h1);
        expect_wb(OP_DEC, 8'hFF, 1'b1);
        tick;
        set_op(OP_RIGHT, 12'd8, 8'h33, 1'b1);
        expect_wb(OP_RIGHT, 8'h33, 1'b1);
        tick;
        set_op(8'h00, 12'd0, 8'h00, 1'b0);
        tick;

        // IN waits three cycles for a byte
        set_op(OP_IN, 12'd4, 8'h00, 1'b1);
        #2;
        check("ack_in_accept", 32'(ack), 32'h1);
        check("in_ready_novalid", 32'(in_ready), 32'h0);
        tick;
        set_op(8'h00, 12'd0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #2;
            check("ack_wait_in", 32'(ack), 32'h0);
            check("in_ready_wait", 32'(in_ready), 32'h0);
            tick;
        end
        in_valid = 1'b1;
        in_data  = 8'h41;
        #2 check("in_ready_pulse", 32'(in_ready), 32'h1);
        expect_wb(OP_IN, 8'h41, 1'b1);
        tick;
        in_valid = 1'b0;
        #2 check("in_ready_after", 32'(in_ready), 32'h0);
        tick;

        // IN with a byte already waiting completes in RUN
        set_op(OP_IN, 12'd11, 8'h00, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h7E;
        #2;
        check("ack_in_direct", 32'(ack), 32'h1);
        check("in_ready_direct", 32'(in_ready), 32'h1);
        expect_wb(OP_IN, 8'h7E, 1'b1);
        tick;
        set_op(8'h00, 12'd0, 8'h00, 1'b0);
        #2 check("in_ready_no_in_op", 32'(in_ready), 32'h0);
        in_valid = 1'b0;
        tick;

        // OUT held two cycles before the sink takes it
        set_op(OP_OUT, 12'd5, 8'h5A, 1'b1);
        #2 check("ack_out", 32'(ack), 32'h1);
        tick;
        set_op(8'h00, 12'd0, 8'h00, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #2;
            check("out_valid_held", 32'(out_valid), 32'h1);
            check("out_data_held", 32'(out_data), 32'h5A);
            check("ack_wait_out", 32'(ack), 32'h0);
            tick;
        end
        out_ready = 1'b1;
        #2 check("out_valid_hs", 32'(out_valid), 32'h1);
        expect_wb(OP_OUT, 8'h5A, 1'b0);
        tick;
        out_ready = 1'b0;
        #2 check("out_valid_clear", 32'(out_valid), 32'h0);
        tick;

        // Back-to-back INC on one cell with stale DRAM data
        for (int i = 0; i < 3; i++) begin
            set_op(OP_INC, 12'd3, 8'h10, 1'b1);
            #2 check("ack_fwd_inc", 32'(ack), 32'h1);
`ifdef EXECUTE_FORWARD_EN
            expect_wb(OP_INC, 8'h11 + 8'(i), 1'b1);
`else
            expect_wb(OP_INC, 8'h11, 1'b1);
`endif
            tick;
        end
        set_op(8'h00, 12'd0, 8'h00, 1'b0);
        tick;

        // Downstream back-pressure
        ack_in = 1'b0;
        set_op(OP_INC, 12'd6, 8'h20, 1'b1);
        for (int i = 0; i < 2; i++) begin
            #2 check("ack_backpressure", 32'(ack), 32'h0);
            tick;
        end
        ack_in = 1'b1;
        #2 check("ack_release", 32'(ack), 32'h1);
        expect_wb(OP_INC, 8'h21, 1'b1);
        tick;
        set_op(OP_DEC, 12'd7, 8'h30, 1'b1);
        expect_wb(OP_DEC, 8'h2F, 1'b1);
        tick;
        set_op(8'h00, 12'd0, 8'h00, 1'b0);
        tick;

        // Operand not yet valid stalls the op
        set_op(OP_INC, 12'd9, 8'h00, 1'b0);
        #2 check("ack_no_drdy", 32'(ack), 32'h0);
        tick;
        d_in    = 8'h7F;
        drdy_in = 1'b1;
        #2 check("ack_drdy", 32'(ack), 32'h1);
        expect_wb(OP_INC, 8'h80, 1'b1);
        tick;
        set_op(8'h00, 12'd0, 8'h00, 1'b0);
        tick;

        // Reset while an OUT is pending discards it
        set_op(OP_OUT, 12'd12, 8'hC3, 1'b1);
        #2 check("ack_out2", 32'(ack), 32'h1);
        tick;
        set_op(8'h00, 12'd0, 8'h00, 1'b0);
        #2 check("out_valid_pending", 32'(out_valid), 32'h1);
        reset = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'h0);
        check("mid_rst_out_data", 32'(out_data), 32'h0);
        check("mid_rst_operation", 32'(operation), 32'h0);
        check("mid_rst_a", 32'(a), 32'h0);
        tick;
        tick;
        reset = 1'b1;
        set_op(OP_INC, 12'd13, 8'h01, 1'b1);
        out_ready = 1'b1;
        #2 check("ack_after_rst", 32'(ack), 32'h1);
        expect_wb(OP_INC, 8'h02, 1'b1);
        tick;
        set_op(8'h00, 12'd0, 8'h00, 1'b0);
        out_ready = 1'b0;
        tick;
        tick;
        #2 check("sb_empty", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
